// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline valid/allowin control and RAW hazard resolution for the NSTAGE
// stages after decode. Stage 0 is EX and stage NSTAGE-1 is WB.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   id_valid, id_flush      decode holds an instruction / kill it instead of issuing
//   id_rs1/2, id_rs1/2_en   decode source registers and read enables
//   id_we, id_waddr         decode destination write enable and register
//   id_late                 decode result is only ready from LOAD_STAGE onward
//   rf_rdata1/2             regfile read data for rs1/rs2
//   st_ready_go, st_flush   per-stage ready_go and kill from the datapath
//   st_result               per-stage current result, slice k = stage k
//   id_ready_go, id_fire    decode not stalled / decode moves into stage 0
//   st_valid, st_allowin    per-stage valid and allowin
//   id_src1/2               resolved operands (forwarded or regfile)
//   rf_we, rf_waddr         regfile write port, from the last stage
//   stall_cnt               wrapping count of stalled decode cycles
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 3,
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int BYPASS     = 1,
  parameter int LOAD_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_flush,
  input  logic [AW-1:0]        id_rs1,
  input  logic [AW-1:0]        id_rs2,
  input  logic                 id_rs1_en,
  input  logic                 id_rs2_en,
  input  logic                 id_we,
  input  logic [AW-1:0]        id_waddr,
  input  logic                 id_late,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic [DW-1:0]        rf_rdata2,
  input  logic [NSTAGE-1:0]    st_ready_go,
  input  logic [NSTAGE*DW-1:0] st_result,
  input  logic [NSTAGE-1:0]    st_flush,
  output logic                 id_ready_go,
  output logic                 id_fire,
  output logic [NSTAGE-1:0]    st_valid,
  output logic [NSTAGE-1:0]    st_allowin,
  output logic [DW-1:0]        id_src1,
  output logic [DW-1:0]        id_src2,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [31:0]          stall_cnt
);

  logic [NSTAGE-1:0]         valid_q, valid_d;
  logic [NSTAGE-1:0]         we_q, we_d;
  logic [NSTAGE-1:0]         late_q, late_d;
  logic [NSTAGE-1:0][AW-1:0] waddr_q, waddr_d;
  logic [31:0]               stall_cnt_q, stall_cnt_d;

  logic [NSTAGE-1:0] allowin;
  logic [DW:0]       res1, res2;
  logic              stall1, stall2;

  // Allowin ripples from WB back towards EX: a stage can take a new entry
  // if it is empty or its current entry can leave this cycle.
  always_comb begin
    allowin = '0;
    allowin[NSTAGE-1] = !valid_q[NSTAGE-1] || st_ready_go[NSTAGE-1];
    for (int k = NSTAGE-2; k >= 0; k--)
      allowin[k] = !valid_q[k] || (st_ready_go[k] && allowin[k+1]);
  end

  // Returns {stall, operand}. Scanning from the oldest stage down lets the
  // youngest matching producer override older ones.
  function automatic logic [DW:0] resolve(input logic [AW-1:0] rs,
                                          input logic          en,
                                          input logic [DW-1:0] rdata);
    logic          stall;
    logic [DW-1:0] data;
    stall = 1'b0;
    data  = rdata;
    for (int k = NSTAGE-1; k >= 0; k--) begin
      if (valid_q[k] && we_q[k] && (waddr_q[k] != '0) && en && (waddr_q[k] == rs)) begin
        if (BYPASS == 0) begin
          stall = 1'b1;
        end else begin
          // A late result seen before LOAD_STAGE is not computed yet.
          stall = late_q[k] && (k < LOAD_STAGE);
          data  = st_result[k*DW +: DW];
        end
      end
    end
    return {stall, data};
  endfunction

  always_comb begin
    res1   = resolve(id_rs1, id_rs1_en, rf_rdata1);
    res2   = resolve(id_rs2, id_rs2_en, rf_rdata2);
    stall1 = res1[DW];
    stall2 = res2[DW];
  end

  assign id_ready_go = !(stall1 || stall2);
  assign id_fire     = id_valid && id_ready_go && allowin[0];
  assign id_src1     = res1[DW-1:0];
  assign id_src2     = res2[DW-1:0];

  // Stage advance. A stage that accepts takes its upstream entry (or a
  // bubble); a stage that holds keeps its entry unless flushed.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    late_d  = late_q;
    waddr_d = waddr_q;
    if (allowin[0]) begin
      valid_d[0] = id_fire && !id_flush;
      we_d[0]    = id_we;
      waddr_d[0] = id_waddr;
      late_d[0]  = id_late;
    end else begin
      valid_d[0] = valid_q[0] && !st_flush[0];
    end
    for (int k = 1; k < NSTAGE; k++) begin
      if (allowin[k]) begin
        valid_d[k] = valid_q[k-1] && st_ready_go[k-1] && !st_flush[k-1];
        we_d[k]    = we_q[k-1];
        waddr_d[k] = waddr_q[k-1];
        late_d[k]  = late_q[k-1];
      end else begin
        valid_d[k] = valid_q[k] && !st_flush[k];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready_go)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      we_q        <= '0;
      late_q      <= '0;
      waddr_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      late_q      <= late_d;
      waddr_q     <= waddr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign st_valid   = valid_q;
  assign st_allowin = allowin;
  assign rf_we      = valid_q[NSTAGE-1] && we_q[NSTAGE-1];
  assign rf_waddr   = waddr_q[NSTAGE-1];
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
// dut uses forwarding (BYPASS=1), sdut is stall-only (BYPASS=0).
module tb_pipe_hazard_ctrl;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [DW-1:0] RD1 = 32'hAAAA_0001;
  localparam logic [DW-1:0] RD2 = 32'hBBBB_0002;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_flush, id_rs1_en, id_rs2_en, id_we, id_late;
  logic [AW-1:0] id_rs1, id_rs2, id_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic [NS-1:0] st_ready_go, st_flush;
  logic [NS*DW-1:0] st_result;

  logic id_ready_go, id_fire, rf_we;
  logic [NS-1:0] st_valid, st_allowin;
  logic [DW-1:0] id_src1, id_src2;
  logic [AW-1:0] rf_waddr;
  logic [31:0] stall_cnt;

  logic s_ready_go, s_fire, s_rf_we;
  logic [NS-1:0] s_valid, s_allowin;
  logic [DW-1:0] s_src1, s_src2;
  logic [AW-1:0] s_rf_waddr;
  logic [31:0] s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGE(NS), .DW(DW), .AW(AW), .BYPASS(1), .LOAD_STAGE(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_we(id_we), .id_waddr(id_waddr), .id_late(id_late),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .st_ready_go(st_ready_go),
    .st_result(st_result), .st_flush(st_flush), .id_ready_go(id_ready_go),
    .id_fire(id_fire), .st_valid(st_valid), .st_allowin(st_allowin),
    .id_src1(id_src1), .id_src2(id_src2), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall_cnt(stall_cnt));

  pipe_hazard_ctrl #(.NSTAGE(NS), .DW(DW), .AW(AW), .BYPASS(0), .LOAD_STAGE(1)) sdut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_we(id_we), .id_waddr(id_waddr), .id_late(id_late),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .st_ready_go(st_ready_go),
    .st_result(st_result), .st_flush(st_flush), .id_ready_go(s_ready_go),
    .id_fire(s_fire), .st_valid(s_valid), .st_allowin(s_allowin),
    .id_src1(s_src1), .id_src2(s_src2), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr),
    .stall_cnt(s_stall_cnt));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_valid = 0; id_flush = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_en = 0; id_rs2_en = 0;
    id_we = 0; id_waddr = '0; id_late = 0; st_ready_go = '1; st_flush = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cyc(); cyc(); reset = 0;
  endtask

  task automatic issue(input logic [AW-1:0] wa, input logic late);
    idle(); id_valid = 1; id_we = 1; id_waddr = wa; id_late = late;
  endtask

  task automatic test_reset();
    do_reset(); settle();
    n_cmp++; if (st_valid !== 3'b000) begin n_err++; $display("FAIL rst_valid: got %b exp 000", st_valid); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we: got %b exp 0", rf_we); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d exp 0", stall_cnt); end
    n_cmp++; if (id_ready_go !== 1'b1) begin n_err++; $display("FAIL rst_ready_go: got %b exp 1", id_ready_go); end
    n_cmp++; if (st_allowin !== 3'b111) begin n_err++; $display("FAIL rst_allowin: got %b exp 111", st_allowin); end
    n_cmp++; if (id_src1 !== RD1) begin n_err++; $display("FAIL rst_src1: got %h exp %h", id_src1, RD1); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] eb [3];
    eb = '{3'b000, 3'b001, 3'b011};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(AW'(i + 1), 1'b0); settle();
      n_cmp++; if (id_fire !== 1'b1) begin n_err++; $display("FAIL b2b_fire%0d: got %b exp 1", i, id_fire); end
      n_cmp++; if (st_valid !== eb[i]) begin n_err++; $display("FAIL b2b_valid%0d: got %b exp %b", i, st_valid, eb[i]); end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_rfwe%0d: got %b exp 0", i, rf_we); end
      cyc();
    end
    idle(); settle();
    n_cmp++; if (st_valid !== 3'b111) begin n_err++; $display("FAIL b2b_valid3: got %b exp 111", st_valid); end
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin n_err++; $display("FAIL b2b_wb1: got we=%b wa=%0d exp we=1 wa=1", rf_we, rf_waddr); end
    cyc(); settle();
    n_cmp++; if (st_valid !== 3'b110) begin n_err++; $display("FAIL b2b_valid4: got %b exp 110", st_valid); end
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2) begin n_err++; $display("FAIL b2b_wb2: got we=%b wa=%0d exp we=1 wa=2", rf_we, rf_waddr); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL b2b_stall_cnt: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    issue(5'd4, 1'b0); settle(); cyc();
    idle(); id_valid = 1; id_rs1 = 5'd4; id_rs1_en = 1; id_rs2 = 5'd9; id_rs2_en = 1; settle();
    n_cmp++; if (id_ready_go !== 1'b1) begin n_err++; $display("FAIL fwd_ex_ready: got %b exp 1", id_ready_go); end
    n_cmp++; if (id_src1 !== 32'h11) begin n_err++; $display("FAIL fwd_ex_src1: got %h exp 00000011", id_src1); end
    n_cmp++; if (id_src2 !== RD2) begin n_err++; $display("FAIL fwd_nomatch_src2: got %h exp %h", id_src2, RD2); end
    cyc(); settle();
    n_cmp++; if (id_src1 !== 32'h22) begin n_err++; $display("FAIL fwd_mem_src1: got %h exp 00000022", id_src1); end
    cyc();
    issue(5'd6, 1'b0); cyc();
    issue(5'd6, 1'b0); cyc();
    idle(); id_valid = 1; id_rs1 = 5'd6; id_rs1_en = 1; id_rs2 = 5'd6; id_rs2_en = 1; settle();
    n_cmp++; if (id_src1 !== 32'h11 || id_src2 !== 32'h11) begin n_err++; $display("FAIL fwd_youngest: got %h/%h exp 00000011/00000011", id_src1, id_src2); end
    n_cmp++; if (id_ready_go !== 1'b1) begin n_err++; $display("FAIL fwd_youngest_ready: got %b exp 1", id_ready_go); end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd5, 1'b1); settle(); cyc();
    idle(); id_valid = 1; id_rs2 = 5'd5; id_rs2_en = 1; settle();
    n_cmp++; if (id_ready_go !== 1'b0 || id_fire !== 1'b0) begin n_err++; $display("FAIL lu_stall: got rg=%b fire=%b exp 0/0", id_ready_go, id_fire); end
    cyc(); settle();
    n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d exp 1", stall_cnt); end
    n_cmp++; if (id_ready_go !== 1'b1 || id_src2 !== 32'h22) begin n_err++; $display("FAIL lu_fwd_mem: got rg=%b src2=%h exp 1/00000022", id_ready_go, id_src2); end
    n_cmp++; if (st_valid !== 3'b010) begin n_err++; $display("FAIL lu_bubble: got %b exp 010", st_valid); end
    cyc(); idle(); settle();
    n_cmp++; if (st_valid !== 3'b101 || stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_after: got v=%b cnt=%0d exp 101/1", st_valid, stall_cnt); end
  endtask

  task automatic test_stall_only();
    do_reset();
    issue(5'd7, 1'b0); settle(); cyc();
    idle(); id_valid = 1; id_rs1 = 5'd7; id_rs1_en = 1; settle();
    n_cmp++; if (s_ready_go !== 1'b0) begin n_err++; $display("FAIL so_ex_stall: got %b exp 0", s_ready_go); end
    n_cmp++; if (id_ready_go !== 1'b1 || id_src1 !== 32'h11) begin n_err++; $display("FAIL so_bypass_ref: got rg=%b src1=%h exp 1/00000011", id_ready_go, id_src1); end
    cyc(); settle();
    n_cmp++; if (s_ready_go !== 1'b0) begin n_err++; $display("FAIL so_mem_stall: got %b exp 0", s_ready_go); end
    cyc(); settle();
    n_cmp++; if (s_ready_go !== 1'b0) begin n_err++; $display("FAIL so_wb_stall: got %b exp 0", s_ready_go); end
    n_cmp++; if (s_rf_we !== 1'b1 || s_rf_waddr !== 5'd7) begin n_err++; $display("FAIL so_wb_write: got we=%b wa=%0d exp 1/7", s_rf_we, s_rf_waddr); end
    cyc(); settle();
    n_cmp++; if (s_ready_go !== 1'b1 || s_src1 !== RD1) begin n_err++; $display("FAIL so_release: got rg=%b src1=%h exp 1/%h", s_ready_go, s_src1, RD1); end
    n_cmp++; if (s_stall_cnt !== 32'd3) begin n_err++; $display("FAIL so_cnt: got %0d exp 3", s_stall_cnt); end
    idle();
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin issue(AW'(i + 1), 1'b0); cyc(); end
    issue(5'd8, 1'b0); st_ready_go = 3'b101; settle();
    n_cmp++; if (st_allowin !== 3'b100 || id_fire !== 1'b0) begin n_err++; $display("FAIL hold_allowin: got a=%b fire=%b exp 100/0", st_allowin, id_fire); end
    cyc(); settle();
    n_cmp++; if (st_valid !== 3'b011 || rf_we !== 1'b0) begin n_err++; $display("FAIL hold_drain: got v=%b we=%b exp 011/0", st_valid, rf_we); end
    n_cmp++; if (id_fire !== 1'b0) begin n_err++; $display("FAIL hold_fire2: got %b exp 0", id_fire); end
    cyc(); settle();
    n_cmp++; if (st_valid !== 3'b011) begin n_err++; $display("FAIL hold_keep: got %b exp 011", st_valid); end
    st_ready_go = 3'b111; settle();
    n_cmp++; if (st_allowin !== 3'b111 || id_fire !== 1'b1) begin n_err++; $display("FAIL hold_release: got a=%b fire=%b exp 111/1", st_allowin, id_fire); end
    cyc(); idle(); settle();
    n_cmp++; if (st_valid !== 3'b111 || rf_waddr !== 5'd2 || rf_we !== 1'b1) begin n_err++; $display("FAIL hold_resume: got v=%b wa=%0d we=%b exp 111/2/1", st_valid, rf_waddr, rf_we); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL hold_cnt: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    issue(5'd0, 1'b1); settle(); cyc();
    issue(5'd5, 1'b1); id_rs1 = 5'd0; id_rs1_en = 1; settle();
    n_cmp++; if (id_ready_go !== 1'b1 || id_src1 !== RD1) begin n_err++; $display("FAIL nh_r0: got rg=%b src1=%h exp 1/%h", id_ready_go, id_src1, RD1); end
    cyc();
    idle(); id_valid = 1; id_rs1 = 5'd5; id_rs1_en = 0; settle();
    n_cmp++; if (id_ready_go !== 1'b1) begin n_err++; $display("FAIL nh_en0: got %b exp 1", id_ready_go); end
    id_rs1_en = 1; settle();
    n_cmp++; if (id_ready_go !== 1'b0) begin n_err++; $display("FAIL nh_en1: got %b exp 0", id_ready_go); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    issue(5'd1, 1'b0); cyc(); issue(5'd2, 1'b0); cyc();
    idle(); st_flush = 3'b001; settle(); cyc(); idle(); settle();
    n_cmp++; if (st_valid !== 3'b100) begin n_err++; $display("FAIL fl_advance: got %b exp 100", st_valid); end
    do_reset();
    for (int i = 0; i < 3; i++) begin issue(AW'(i + 1), 1'b0); cyc(); end
    idle(); st_ready_go = 3'b101; st_flush = 3'b010; settle(); cyc(); idle(); settle();
    n_cmp++; if (st_valid !== 3'b001) begin n_err++; $display("FAIL fl_stalled: got %b exp 001", st_valid); end
    do_reset();
    issue(5'd3, 1'b0); id_flush = 1; settle();
    n_cmp++; if (id_fire !== 1'b1) begin n_err++; $display("FAIL fl_id_fire: got %b exp 1", id_fire); end
    cyc(); idle(); settle();
    n_cmp++; if (st_valid !== 3'b000) begin n_err++; $display("FAIL fl_id_kill: got %b exp 000", st_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(5'd5, 1'b1); cyc();
    issue(5'd9, 1'b0); id_rs1 = 5'd5; id_rs1_en = 1; cyc();
    cyc();
    issue(5'd10, 1'b0); cyc();
    issue(5'd11, 1'b0); cyc();
    settle();
    n_cmp++; if (st_valid !== 3'b111 || stall_cnt !== 32'd1) begin n_err++; $display("FAIL rm_pre: got v=%b cnt=%0d exp 111/1", st_valid, stall_cnt); end
    reset = 1; cyc(); settle();
    n_cmp++; if (st_valid !== 3'b000 || stall_cnt !== 32'd0 || rf_we !== 1'b0) begin n_err++; $display("FAIL rm_post: got v=%b cnt=%0d we=%b exp 000/0/0", st_valid, stall_cnt, rf_we); end
    reset = 0; idle();
  endtask

  initial begin
    reset = 1;
    idle();
    rf_rdata1 = RD1;
    rf_rdata2 = RD2;
    st_result = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    test_reset();
    test_back_to_back();
    test_forward();
    test_load_use();
    test_stall_only();
    test_hold();
    test_no_hazard();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
